// File: rtl/prio_load_pipe_reg.sv
// prio_load_pipe_reg: W-bit pipeline register with NPORTS priority-ordered
// load ports and a DEPTH-stage delay line. Each stage carries data, a valid
// bit and the index of the port that loaded it. Flush beats stall, and stall
// beats loading. An idle stage 0 holds its data and source but drops valid.

// One stage of the delay line: async reset, sync flush, stall hold.
module prio_load_pipe_stage #(
    parameter int            EW      = 1,
    parameter logic [EW-1:0] RST_ENT = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          stall,
    input  logic [EW-1:0] nxt,
    output logic [EW-1:0] cur
);

    // Reset/flush restore the reset entry; stall freezes; otherwise advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        cur <= RST_ENT;
        else if (flush) cur <= RST_ENT;
        else if (!stall) cur <= nxt;
    end

endmodule

module prio_load_pipe_reg #(
    parameter int             W       = 32,
    parameter int             NPORTS  = 2,
    parameter int             DEPTH   = 1,
    parameter logic [W-1:0]   RST_VAL = {W{1'b1}},
    localparam int            SRCW    = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [NPORTS-1:0]     en,
    input  logic [NPORTS*W-1:0]   d,
    output logic [W-1:0]          q,
    output logic                  q_valid,
    output logic [SRCW-1:0]       q_src,
    output logic [W-1:0]          s0_q
);

    typedef struct packed {
        logic            vld;
        logic [SRCW-1:0] src;
        logic [W-1:0]    data;
    } stage_t;

    localparam int     EW      = $bits(stage_t);
    localparam stage_t RST_ENT = '{vld: 1'b0, src: '0, data: RST_VAL};

    stage_t [DEPTH-1:0] stg;
    stage_t             nxt0;
    logic               win_any;
    logic [SRCW-1:0]    win_src;
    logic [W-1:0]       win_data;

    // Fixed-priority pick: scanning from the top down lets the lowest
    // enabled port index overwrite any higher one.
    always_comb begin
        win_any  = 1'b0;
        win_src  = '0;
        win_data = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (en[i]) begin
                win_any  = 1'b1;
                win_src  = SRCW'(i);
                win_data = d[i*W +: W];
            end
        end
    end

    // Stage 0 next value: the winning load, or a bubble that keeps the old
    // data and source so idle cycles do not disturb forwarded state.
    always_comb begin
        nxt0     = stg[0];
        nxt0.vld = 1'b0;
        if (win_any) begin
            nxt0.vld  = 1'b1;
            nxt0.src  = win_src;
            nxt0.data = win_data;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stg
        if (k == 0) begin : g_head
            prio_load_pipe_stage #(.EW(EW), .RST_ENT(RST_ENT)) u_stage (
                .clk   (clk),
                .rst   (rst),
                .flush (flush),
                .stall (stall),
                .nxt   (nxt0),
                .cur   (stg[k])
            );
        end else begin : g_body
            prio_load_pipe_stage #(.EW(EW), .RST_ENT(RST_ENT)) u_stage (
                .clk   (clk),
                .rst   (rst),
                .flush (flush),
                .stall (stall),
                .nxt   (stg[k-1]),
                .cur   (stg[k])
            );
        end
    end

    assign q       = stg[DEPTH-1].data;
    assign q_valid = stg[DEPTH-1].vld;
    assign q_src   = stg[DEPTH-1].src;
    assign s0_q    = stg[0].data;

endmodule

// File: tb/tb_prio_load_pipe_reg.sv
// Directed bench for prio_load_pipe_reg: the default-style instance
// (W=8, NPORTS=2, DEPTH=2, RST_VAL=FF) plus a single-port, single-stage
// instance (W=32, NPORTS=1, DEPTH=1, RST_VAL=0).
module tb_prio_load_pipe_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A
    logic        rst_a = 1'b0, stall_a = 1'b0, flush_a = 1'b0;
    logic [1:0]  en_a = '0;
    logic [15:0] d_a = '0;
    logic [7:0]  q_a, s0_a;
    logic        qv_a;
    logic [0:0]  qs_a;

    // Instance B
    logic        rst_b = 1'b1, stall_b = 1'b0, flush_b = 1'b0;
    logic [0:0]  en_b = '0;
    logic [31:0] d_b = '0;
    logic [31:0] q_b, s0_b;
    logic        qv_b;
    logic [0:0]  qs_b;

    int errors = 0;
    int checks = 0;

    prio_load_pipe_reg #(.W(8), .NPORTS(2), .DEPTH(2), .RST_VAL(8'hFF)) dut_a (
        .clk(clk), .rst(rst_a), .stall(stall_a), .flush(flush_a), .en(en_a), .d(d_a),
        .q(q_a), .q_valid(qv_a), .q_src(qs_a), .s0_q(s0_a)
    );

    prio_load_pipe_reg #(.W(32), .NPORTS(1), .DEPTH(1), .RST_VAL(32'h0)) dut_b (
        .clk(clk), .rst(rst_b), .stall(stall_b), .flush(flush_b), .en(en_b), .d(d_b),
        .q(q_b), .q_valid(qv_b), .q_src(qs_b), .s0_q(s0_b)
    );

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        rst_a = 1'b1;
        #1;
        checks++;
        if ({qv_a, qs_a, q_a, s0_a} !== {1'b0, 1'b0, 8'hFF, 8'hFF}) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", {qv_a, qs_a, q_a, s0_a}, {1'b0, 1'b0, 8'hFF, 8'hFF});
        end
        #1 rst_a = 1'b0;
        en_a = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({qv_a, qs_a, q_a, s0_a} !== {1'b0, 1'b0, 8'hFF, 8'hFF}) begin
                errors++;
                $display("FAIL reset_idle%0d: got %h want %h", i, {qv_a, qs_a, q_a, s0_a}, {1'b0, 1'b0, 8'hFF, 8'hFF});
            end
        end
    endtask

    task automatic test_priority();
        en_a = 2'b11; d_a = {8'h34, 8'h12};
        step();
        checks++;
        if ({qv_a, qs_a, q_a, s0_a} !== {1'b0, 1'b0, 8'hFF, 8'h12}) begin
            errors++;
            $display("FAIL prio_both: got %h want %h", {qv_a, qs_a, q_a, s0_a}, {1'b0, 1'b0, 8'hFF, 8'h12});
        end
        en_a = 2'b10; d_a = {8'h56, 8'h99};
        step();
        checks++;
        if ({qv_a, qs_a, q_a, s0_a} !== {1'b1, 1'b0, 8'h12, 8'h56}) begin
            errors++;
            $display("FAIL prio_p0_out: got %h want %h", {qv_a, qs_a, q_a, s0_a}, {1'b1, 1'b0, 8'h12, 8'h56});
        end
        en_a = 2'b00;
        step();
        checks++;
        if ({qv_a, qs_a, q_a, s0_a} !== {1'b1, 1'b1, 8'h56, 8'h56}) begin
            errors++;
            $display("FAIL prio_p1_out: got %h want %h", {qv_a, qs_a, q_a, s0_a}, {1'b1, 1'b1, 8'h56, 8'h56});
        end
    endtask

    task automatic test_hold_bubble();
        en_a = 2'b01; d_a = {8'h00, 8'hA5};
        step();
        checks++;
        if ({qv_a, qs_a, q_a, s0_a} !== {1'b0, 1'b1, 8'h56, 8'hA5}) begin
            errors++;
            $display("FAIL hold_load: got %h want %h", {qv_a, qs_a, q_a, s0_a}, {1'b0, 1'b1, 8'h56, 8'hA5});
        end
        en_a = 2'b00;
        step();
        checks++;
        if ({qv_a, qs_a, q_a, s0_a} !== {1'b1, 1'b0, 8'hA5, 8'hA5}) begin
            errors++;
            $display("FAIL hold_valid: got %h want %h", {qv_a, qs_a, q_a, s0_a}, {1'b1, 1'b0, 8'hA5, 8'hA5});
        end
        step();
        checks++;
        if ({qv_a, qs_a, q_a, s0_a} !== {1'b0, 1'b0, 8'hA5, 8'hA5}) begin
            errors++;
            $display("FAIL hold_bubble: got %h want %h", {qv_a, qs_a, q_a, s0_a}, {1'b0, 1'b0, 8'hA5, 8'hA5});
        end
    endtask

    task automatic test_stall();
        en_a = 2'b01; d_a = {8'h00, 8'h01};
        step();
        checks++;
        if ({qv_a, qs_a, q_a, s0_a} !== {1'b0, 1'b0, 8'hA5, 8'h01}) begin
            errors++;
            $display("FAIL stall_load: got %h want %h", {qv_a, qs_a, q_a, s0_a}, {1'b0, 1'b0, 8'hA5, 8'h01});
        end
        stall_a = 1'b1; en_a = 2'b01; d_a = {8'h00, 8'h99};
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({qv_a, qs_a, q_a, s0_a} !== {1'b0, 1'b0, 8'hA5, 8'h01}) begin
                errors++;
                $display("FAIL stall_hold%0d: got %h want %h", i, {qv_a, qs_a, q_a, s0_a}, {1'b0, 1'b0, 8'hA5, 8'h01});
            end
        end
        stall_a = 1'b0; en_a = 2'b00;
        step();
        checks++;
        if ({qv_a, qs_a, q_a, s0_a} !== {1'b1, 1'b0, 8'h01, 8'h01}) begin
            errors++;
            $display("FAIL stall_release: got %h want %h", {qv_a, qs_a, q_a, s0_a}, {1'b1, 1'b0, 8'h01, 8'h01});
        end
    endtask

    task automatic test_flush();
        en_a = 2'b01; d_a = {8'h00, 8'h11};
        step();
        d_a = {8'h00, 8'h22};
        step();
        checks++;
        if ({qv_a, qs_a, q_a, s0_a} !== {1'b1, 1'b0, 8'h11, 8'h22}) begin
            errors++;
            $display("FAIL flush_fill: got %h want %h", {qv_a, qs_a, q_a, s0_a}, {1'b1, 1'b0, 8'h11, 8'h22});
        end
        flush_a = 1'b1; stall_a = 1'b1; en_a = 2'b01; d_a = {8'h00, 8'h77};
        step();
        checks++;
        if ({qv_a, qs_a, q_a, s0_a} !== {1'b0, 1'b0, 8'hFF, 8'hFF}) begin
            errors++;
            $display("FAIL flush_over_stall: got %h want %h", {qv_a, qs_a, q_a, s0_a}, {1'b0, 1'b0, 8'hFF, 8'hFF});
        end
        flush_a = 1'b0; stall_a = 1'b0; en_a = 2'b00;
    endtask

    task automatic test_back_to_back();
        en_a = 2'b10; d_a = {8'hAA, 8'h00};
        step();
        checks++;
        if ({qv_a, qs_a, q_a, s0_a} !== {1'b0, 1'b0, 8'hFF, 8'hAA}) begin
            errors++;
            $display("FAIL b2b_first: got %h want %h", {qv_a, qs_a, q_a, s0_a}, {1'b0, 1'b0, 8'hFF, 8'hAA});
        end
        en_a = 2'b01; d_a = {8'hCC, 8'hBB};
        step();
        checks++;
        if ({qv_a, qs_a, q_a, s0_a} !== {1'b1, 1'b1, 8'hAA, 8'hBB}) begin
            errors++;
            $display("FAIL b2b_second: got %h want %h", {qv_a, qs_a, q_a, s0_a}, {1'b1, 1'b1, 8'hAA, 8'hBB});
        end
        en_a = 2'b00;
        step();
        checks++;
        if ({qv_a, qs_a, q_a, s0_a} !== {1'b1, 1'b0, 8'hBB, 8'hBB}) begin
            errors++;
            $display("FAIL b2b_drain: got %h want %h", {qv_a, qs_a, q_a, s0_a}, {1'b1, 1'b0, 8'hBB, 8'hBB});
        end
    endtask

    task automatic test_midstream_reset();
        en_a = 2'b10; d_a = {8'hC3, 8'h00};
        step();
        d_a = {8'h3C, 8'h00};
        step();
        #1 rst_a = 1'b1;
        #1;
        checks++;
        if ({qv_a, qs_a, q_a, s0_a} !== {1'b0, 1'b0, 8'hFF, 8'hFF}) begin
            errors++;
            $display("FAIL mid_reset: got %h want %h", {qv_a, qs_a, q_a, s0_a}, {1'b0, 1'b0, 8'hFF, 8'hFF});
        end
        #1 rst_a = 1'b0;
        en_a = 2'b00;
        step();
        checks++;
        if ({qv_a, qs_a, q_a, s0_a} !== {1'b0, 1'b0, 8'hFF, 8'hFF}) begin
            errors++;
            $display("FAIL mid_reset_after: got %h want %h", {qv_a, qs_a, q_a, s0_a}, {1'b0, 1'b0, 8'hFF, 8'hFF});
        end
    endtask

    task automatic test_param();
        checks++;
        if ({qv_b, qs_b, q_b, s0_b} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL p1_reset: got %h want %h", {qv_b, qs_b, q_b, s0_b}, {1'b0, 1'b0, 32'h0, 32'h0});
        end
        rst_b = 1'b0;
        en_b = 1'b1; d_b = 32'hDEADBEEF;
        step();
        checks++;
        if ({qv_b, qs_b, q_b, s0_b} !== {1'b1, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL p1_load: got %h want %h", {qv_b, qs_b, q_b, s0_b}, {1'b1, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF});
        end
        en_b = 1'b0; d_b = 32'h0BAD0BAD;
        step();
        checks++;
        if ({qv_b, qs_b, q_b, s0_b} !== {1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL p1_hold: got %h want %h", {qv_b, qs_b, q_b, s0_b}, {1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF});
        end
        en_b = 1'b1; d_b = 32'h12345678;
        step();
        checks++;
        if ({qv_b, qs_b, q_b, s0_b} !== {1'b1, 1'b0, 32'h12345678, 32'h12345678}) begin
            errors++;
            $display("FAIL p1_reload: got %h want %h", {qv_b, qs_b, q_b, s0_b}, {1'b1, 1'b0, 32'h12345678, 32'h12345678});
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_hold_bubble();
        test_stall();
        test_flush();
        test_back_to_back();
        test_midstream_reset();
        test_param();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prio_load_pipe_reg.md
Name: prio_load_pipe_reg

Overview:
- Parametrised successor to the single-bit dual-enable flip-flop used in the pipeline datapath.
- W-bit value, NPORTS priority-ordered load ports, DEPTH-stage delay line.
- Per-stage valid bits; stall, flush and source-port tagging.
- Used for pipeline-carried state such as the PC and control words: ports are the load sources, stall comes from the hazard unit, flush comes from branch resolution.

Parameters:
- W, 32, data width in bits (≥1).
- NPORTS, 2, number of load ports (≥1). Port 0 has highest priority.
- DEPTH, 1, number of register stages (≥1). Load-to-output latency in cycles.
- RST_VAL, {W{1'b1}}, data value loaded by reset and by flush.
- SRCW, $clog2(NPORTS) or 1 if NPORTS==1, width of the source tag (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  freezes all stages; en and d are ignored.
- flush  in  1  synchronous clear of all stages; beats stall.
- en  in  NPORTS  per-port load enable; bit i belongs to port i.
- d  in  NPORTS*W  packed load data; port i is d[i*W +: W].
- q  out  W  data of the last stage.
- q_valid  out  1  valid bit of the last stage.
- q_src  out  SRCW  index of the port that loaded the current q.
- s0_q  out  W  data of stage 0, for forwarding; equals q when DEPTH==1.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - every stage: data=RST_VAL, valid=0, src=0.
  - outputs: q=RST_VAL, s0_q=RST_VAL, q_valid=0, q_src=0.
  - reset has precedence over every other input.
  - asserting reset mid-operation discards all stages at once; no partial state survives.
- Per rising clk edge, in priority order:
  1. flush=1: all stages take data=RST_VAL, valid=0, src=0, regardless of stall and en.
  2. stall=1 (flush=0): all stages hold data, valid and src.
  3. Otherwise, stage k (k≥1) takes the contents of stage k-1, and stage 0 updates as follows:
     - ≥1 en bit set: winner p = lowest index with en[p]=1. Stage 0 takes data=d[p], valid=1, src=p. Higher-numbered ports are ignored that cycle.
     - no en bit set: stage 0 data and src hold their previous values (same hold semantics as the dual-enable flip-flop), and valid=0.
- Latency: a load accepted at edge n appears on q with q_valid=1 after edge n+DEPTH-1.
  - DEPTH=1: visible right after the accepting edge.
  - A stall cycle adds one cycle of latency to every in-flight entry.
- Bubbles propagate down the stages as valid=0. Their data is don't-care for consumers but must follow the rule above, so the bench can compare exactly.
- Priority is strictly fixed. There is no round-robin and no starvation handling.
- NPORTS=1: q_src is constant 0.
- Stall combined with en: the load is lost. Stage 0 keeps its old contents and nothing is queued.
- Flush combined with en: the load is lost.
- Outputs come directly from flops; there is no combinational path from inputs to outputs.
- Widths: d slicing is exact, with no sign or zero extension. src is stored in SRCW bits.

Test Plan (W=8, NPORTS=2, DEPTH=2, RST_VAL=8'hFF unless stated):
- Reset check: pulse rst between clock edges -> q=FF, s0_q=FF, q_valid=0 and q_src=0 immediately. Release rst with en=0 for 3 edges -> outputs unchanged.
- Priority: edge 1 drives en=2'b11, d0=8'h12, d1=8'h34 -> s0_q=12 after edge 1; after edge 2, q=12, q_valid=1, q_src=0. With en=2'b10 and d1=8'h56 -> q=56, q_src=1 two edges later.
- Hold plus bubble: load 8'hA5, then drive en=0 -> s0_q stays A5 and the valid bit clears. q shows A5 with q_valid=1 for one cycle, then A5 with q_valid=0.
- Stall: load 8'h01 at edge 1. Assert stall for edges 2–3 while en=2'b01 and d0=8'h99 -> q does not update until edge 4. q=01 with q_valid=1 after edge 4, and 99 never appears.
- Flush over stall: with the pipe full (stage values 11 and 22, both valid), assert flush and stall together with en=2'b01 -> after that edge q=FF, s0_q=FF, q_valid=0, q_src=0.
- Mid-stream async reset plus parametrisation: assert rst between edges during a stream of loads -> outputs are at reset values immediately. Repeat the priority test with NPORTS=1, DEPTH=1, W=32, RST_VAL=0 -> load-to-output latency is 1 edge and q_src stays 0.
